// File: rtl/multi_digit_7sd_counter.sv
// Multi-digit hex/BCD up/down counter with IDLE/AUTO/STEP/LOAD modes and registered 7-segment outputs.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module multi_digit_7sd_counter #(
    parameter int unsigned NUM_DIGITS = 2,
    parameter int unsigned TICK_DIV   = 25000000
) (
    input  logic                    i_Clk,
    input  logic                    i_Reset,
    input  logic [1:0]              i_Mode,
    input  logic                    i_Step,
    input  logic                    i_Up_Down,
    input  logic                    i_Decimal,
    input  logic [4*NUM_DIGITS-1:0] i_Load_Value,
    output logic [4*NUM_DIGITS-1:0] o_Count,
    output logic [7*NUM_DIGITS-1:0] o_Segments,
    output logic                    o_Wrap
);

    localparam int unsigned CW = 4 * NUM_DIGITS;
    localparam int unsigned SW = 7 * NUM_DIGITS;
    localparam int unsigned TW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AUTO = 2'd1,
        S_STEP = 2'd2,
        S_LOAD = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic            step_hist_q, step_hist_d;
    logic            step_pend_q, step_pend_d;
    logic            dec_q, dec_d;
    logic [CW-1:0]   count_q, count_d;
    logic            wrap_q, wrap_d;
    logic [SW-1:0]   seg_q, seg_d;

    logic            mode_change;
    logic            tick_wrap;
    logic            do_inc;
    logic            carry_out;
    logic [CW-1:0]   count_next;

    // Active-low glyph, bit 0 = segment A ... bit 6 = segment G.
    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] on;
        case (d)
            4'h0: on = 7'h3F;
            4'h1: on = 7'h06;
            4'h2: on = 7'h5B;
            4'h3: on = 7'h4F;
            4'h4: on = 7'h66;
            4'h5: on = 7'h6D;
            4'h6: on = 7'h7D;
            4'h7: on = 7'h07;
            4'h8: on = 7'h7F;
            4'h9: on = 7'h6F;
            4'hA: on = 7'h77;
            4'hB: on = 7'h7C;
            4'hC: on = 7'h39;
            4'hD: on = 7'h5E;
            4'hE: on = 7'h79;
            default: on = 7'h71;
        endcase
        return ~on;
    endfunction

    function automatic logic [SW-1:0] decode_all(input logic [CW-1:0] c);
        logic [SW-1:0] s;
`ifdef LEADING_ZERO_BLANK_EN
        logic lead;
        lead = 1'b1;
`endif
        s = '1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            s[7*k +: 7] = glyph(c[4*k +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
            if (lead && (k != 0) && (c[4*k +: 4] == 4'd0)) s[7*k +: 7] = 7'h7F;
            if (c[4*k +: 4] != 4'd0) lead = 1'b0;
`endif
        end
        return s;
    endfunction

    // Ripple one unit through the digits; MSB of the result is the wrap carry/borrow.
    function automatic logic [CW:0] bump(input logic [CW-1:0] c, input logic up, input logic bcd);
        logic [CW-1:0] r;
        logic          carry;
        logic [3:0]    d;
        logic [3:0]    mx;
        mx    = bcd ? 4'd9 : 4'd15;
        carry = 1'b1;
        r     = c;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            d = c[4*k +: 4];
            if (carry) begin
                if (up) begin
                    if (d == mx) d = 4'd0;
                    else begin d = d + 4'd1; carry = 1'b0; end
                end else begin
                    if (d == 4'd0) d = mx;
                    else begin d = d - 4'd1; carry = 1'b0; end
                end
            end
            r[4*k +: 4] = d;
        end
        return {carry, r};
    endfunction

    function automatic logic [CW-1:0] clamp_load(input logic [CW-1:0] v, input logic bcd);
        logic [CW-1:0] r;
        r = v;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (bcd && (v[4*k +: 4] > 4'd9)) r[4*k +: 4] = 4'd9;
        end
        return r;
    endfunction

    always_comb begin
        state_d     = S_IDLE;
        step_hist_d = i_Step;
        dec_d       = i_Decimal;
        tick_d      = '0;
        tick_wrap   = 1'b0;
        count_d     = count_q;
        wrap_d      = 1'b0;

        case (i_Mode)
            2'b00:   state_d = S_IDLE;
            2'b01:   state_d = S_AUTO;
            2'b10:   state_d = S_STEP;
            default: state_d = S_LOAD;
        endcase
        mode_change = (state_d != state_q);

        // Edges seen outside STEP never become pending.
        step_pend_d = i_Step & ~step_hist_q & (state_q == S_STEP);

        if ((state_q == S_AUTO) && !mode_change) begin
            if (tick_q == TW'(TICK_DIV - 1)) tick_wrap = 1'b1;
            else                             tick_d    = tick_q + TW'(1);
        end

        do_inc = !mode_change && (tick_wrap || ((state_q == S_STEP) && step_pend_q));
        {carry_out, count_next} = bump(count_q, i_Up_Down, i_Decimal);

        if (i_Decimal != dec_q) begin
            count_d = '0;
        end else if (state_q == S_LOAD) begin
            count_d = clamp_load(i_Load_Value, i_Decimal);
        end else if (do_inc) begin
            count_d = count_next;
            wrap_d  = carry_out;
        end

        seg_d = decode_all(count_q);
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q     <= S_IDLE;
            tick_q      <= '0;
            step_hist_q <= 1'b0;
            step_pend_q <= 1'b0;
            dec_q       <= i_Decimal;
            count_q     <= '0;
            wrap_q      <= 1'b0;
            seg_q       <= '1;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            step_hist_q <= step_hist_d;
            step_pend_q <= step_pend_d;
            dec_q       <= dec_d;
            count_q     <= count_d;
            wrap_q      <= wrap_d;
            seg_q       <= seg_d;
        end
    end

    assign o_Count    = count_q;
    assign o_Segments = seg_q;
    assign o_Wrap     = wrap_q;

endmodule

// File: tb/tb_multi_digit_7sd_counter.sv
// Scoreboard bench for multi_digit_7sd_counter: an integer-valued reference model queues expected outputs each cycle.
module tb_multi_digit_7sd_counter;

    localparam int ND = 2;
    localparam int TD = 4;
    localparam int CW = 4 * ND;
    localparam int SW = 7 * ND;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    mode;
    logic          step;
    logic          up;
    logic          dec;
    logic [CW-1:0] load;
    logic [CW-1:0] cnt;
    logic [SW-1:0] seg;
    logic          wrap;

    multi_digit_7sd_counter #(.NUM_DIGITS(ND), .TICK_DIV(TD)) dut (
        .i_Clk        (clk),
        .i_Reset      (rst),
        .i_Mode       (mode),
        .i_Step       (step),
        .i_Up_Down    (up),
        .i_Decimal    (dec),
        .i_Load_Value (load),
        .o_Count      (cnt),
        .o_Segments   (seg),
        .o_Wrap       (wrap)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] cnt;
        logic          wrap;
        logic [SW-1:0] seg;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [6:0] glyph(input int d);
        logic [6:0] on [16];
        on = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return ~on[d];
    endfunction

    function automatic logic [SW-1:0] segs_of(input logic [CW-1:0] c);
        logic [SW-1:0] s;
        bit higher_nz;
        int d;
        higher_nz = 1'b0;
        s = '1;
        for (int k = ND - 1; k >= 0; k--) begin
            d = int'(c[4*k +: 4]);
            s[7*k +: 7] = glyph(d);
`ifdef LEADING_ZERO_BLANK_EN
            if (k > 0 && !higher_nz && d == 0) s[7*k +: 7] = 7'h7F;
`endif
            if (d != 0) higher_nz = 1'b1;
        end
        return s;
    endfunction

    function automatic logic [CW-1:0] pack(input int n, input int r);
        logic [CW-1:0] c;
        int p;
        p = 1;
        c = '0;
        for (int k = 0; k < ND; k++) begin
            c[4*k +: 4] = 4'((n / p) % r);
            p = p * r;
        end
        return c;
    endfunction

    // Reference model: count kept as a plain integer in the active radix.
    initial begin
        int   m_state, m_tick, m_n, r, top, p, d;
        bit   m_hist, m_pend, m_dec, changed, rise, fire;
        logic [CW-1:0] m_cnt;
        exp_t e;
        m_state = 0; m_tick = 0; m_n = 0; m_hist = 0; m_pend = 0; m_dec = 0; m_cnt = '0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_state = 0; m_tick = 0; m_n = 0; m_hist = 0; m_pend = 0; m_dec = dec;
                m_cnt = '0;
                e.cnt = '0; e.wrap = 1'b0; e.seg = '1;
            end else begin
                e.seg  = segs_of(m_cnt);
                e.wrap = 1'b0;
                r   = dec ? 10 : 16;
                top = 1;
                for (int k = 0; k < ND; k++) top = top * r;
                top = top - 1;
                changed = (int'(mode) != m_state);
                rise    = step && !m_hist;
                fire    = !changed && ((m_state == 1 && m_tick == TD - 1) || (m_state == 2 && m_pend));
                if (dec != m_dec) begin
                    m_n = 0;
                end else if (m_state == 3) begin
                    m_n = 0; p = 1;
                    for (int k = 0; k < ND; k++) begin
                        d = int'(load[4*k +: 4]);
                        if (dec && d > 9) d = 9;
                        m_n = m_n + d * p;
                        p = p * r;
                    end
                end else if (fire) begin
                    if (up) begin
                        if (m_n == top) begin m_n = 0; e.wrap = 1'b1; end
                        else m_n = m_n + 1;
                    end else begin
                        if (m_n == 0) begin m_n = top; e.wrap = 1'b1; end
                        else m_n = m_n - 1;
                    end
                end
                m_tick  = (!changed && m_state == 1) ? (m_tick + 1) % TD : 0;
                m_pend  = rise && (m_state == 2);
                m_hist  = step;
                m_state = int'(mode);
                m_dec   = dec;
                m_cnt   = pack(m_n, r);
                e.cnt   = m_cnt;
            end
            q.push_back(e);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: outputs are presented every cycle, compare against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() == 0) begin
                check("queue_empty", 32'd0, 32'd1);
            end else begin
                e = q.pop_front();
                check("count", 32'(cnt), 32'(e.cnt));
                check("wrap", 32'(wrap), 32'(e.wrap));
                check("segments", 32'(seg), 32'(e.seg));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int sel;
        rst = 1'b1; mode = 2'b00; step = 1'b0; up = 1'b1; dec = 1'b0; load = '0;
        cyc(2);
        rst = 1'b0;
        cyc(2);
        // hex auto count through a digit carry
        mode = 2'b01; cyc(70);
        // BCD wrap up then down via single steps
        mode = 2'b00; dec = 1'b1; cyc(2);
        mode = 2'b11; load = 8'h99; cyc(3);
        mode = 2'b10; cyc(2);
        step = 1'b1; cyc(3); step = 1'b0; cyc(2);
        up = 1'b0;
        step = 1'b1; cyc(3); step = 1'b0; cyc(2);
        up = 1'b1;
        // BCD load clamp, then decimal toggle clears
        mode = 2'b11; load = 8'hAB; cyc(3);
        mode = 2'b00; dec = 1'b0; cyc(3);
        // reset collides with a step edge
        mode = 2'b11; load = 8'h05; cyc(2);
        mode = 2'b10; cyc(2);
        step = 1'b1; rst = 1'b1; cyc(1);
        rst = 1'b0; step = 1'b0; cyc(4);
        // step edge in AUTO is discarded after switching to STEP
        mode = 2'b11; load = 8'h07; cyc(2);
        mode = 2'b01; cyc(1);
        step = 1'b1; cyc(1);
        mode = 2'b10; cyc(3);
        step = 1'b0; cyc(3);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) step = ~step;
            if ($urandom_range(0, 149) == 0) dec = ~dec;
            if ($urandom_range(0, 49) == 0) up = ~up;
            sel = int'($urandom_range(0, 3));
            case (sel)
                0: load = 8'h00;
                1: load = 8'h99;
                2: load = 8'hFF;
                default: load = 8'($urandom);
            endcase
            cyc(1);
        end
        rst = 1'b0;
        cyc(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
